// File: rtl/fetch_unit_pkg.sv
// Shared fetch-side definitions: fetch width, packet format, FSM states and block helpers.
// The `N and `NUM_SCALAR_BITS macros can be predefined by the build; defaults are 3 and 2.
`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS $clog2(`N + 1)
`endif

package fetch_unit_pkg;

    localparam int FETCH_WIDTH               = `N;
    localparam int SCALAR_BITS               = `NUM_SCALAR_BITS;
    localparam int DEFAULT_FETCH_BLOCK_INSTS = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
    } FETCH_PACKET;

    typedef enum logic [0:0] {
        FETCH     = 1'b0,
        MISS_WAIT = 1'b1
    } fetch_state_t;

    // Byte address of the start of the block containing pc.
    function automatic logic [31:0] block_base(input logic [31:0] pc, input int ofs_bits);
        return pc & ~((32'd1 << (ofs_bits + 2)) - 32'd1);
    endfunction

    // Word offset of pc within its block.
    function automatic logic [31:0] block_word_ofs(input logic [31:0] pc, input int ofs_bits);
        return (pc >> 2) & ((32'd1 << ofs_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// I-cache request/response and instruction-buffer write bundle between the fetch unit and its neighbours.
interface fetch_unit_if
#(
    parameter int FETCH_BLOCK_INSTS = fetch_unit_pkg::DEFAULT_FETCH_BLOCK_INSTS
) ();

    logic                                               icache_req_valid;
    logic [31:0]                                        icache_req_addr;
    logic                                               icache_hit;
    logic [32*FETCH_BLOCK_INSTS-1:0]                    icache_data;
    logic [fetch_unit_pkg::SCALAR_BITS-1:0]             inst_buffer_spots;
    fetch_unit_pkg::FETCH_PACKET [fetch_unit_pkg::FETCH_WIDTH-1:0] inst_buffer_inputs;
    logic [fetch_unit_pkg::SCALAR_BITS-1:0]             instructions_valid;

    modport master (
        output icache_req_valid,
        output icache_req_addr,
        input  icache_hit,
        input  icache_data,
        input  inst_buffer_spots,
        output inst_buffer_inputs,
        output instructions_valid
    );

    modport slave (
        input  icache_req_valid,
        input  icache_req_addr,
        output icache_hit,
        output icache_data,
        output inst_buffer_spots,
        input  inst_buffer_inputs,
        input  instructions_valid
    );

endinterface

// File: rtl/fetch_unit_count_calc.sv
// Lanes deliverable this cycle: min of fetch width, free buffer slots and words left in the block.
module fetch_count_calc
    import fetch_unit_pkg::*;
#(
    parameter int FETCH_BLOCK_INSTS = DEFAULT_FETCH_BLOCK_INSTS
) (
    input  logic [SCALAR_BITS-1:0] spots,
    input  logic [31:0]            blk_ofs,
    output logic [SCALAR_BITS-1:0] count
);

    logic [31:0] remain_s;
    logic [31:0] lim_s;

    // Three-way minimum in 32-bit arithmetic so every operand compares at full width.
    always_comb begin
        remain_s = 32'(FETCH_BLOCK_INSTS) - blk_ofs;
        lim_s    = 32'(FETCH_WIDTH);
        if (32'(spots) < lim_s) begin
            lim_s = 32'(spots);
        end else begin
            lim_s = lim_s;
        end
        if (remain_s < lim_s) begin
            lim_s = remain_s;
        end else begin
            lim_s = lim_s;
        end
        count = lim_s[SCALAR_BITS-1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: holds the fetch PC, requests I-cache blocks and writes in-order packets to the buffer.
// Optional FETCH_STATS_EN adds fetched-instruction, miss-cycle and buffer-full cycle counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int FETCH_BLOCK_INSTS = DEFAULT_FETCH_BLOCK_INSTS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         restore_valid,
    input  logic [31:0]  restore_pc,
    fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]  stat_insts_fetched,
    output logic [31:0]  stat_miss_cycles,
    output logic [31:0]  stat_full_cycles
`endif
);

    localparam int BLK_OFS_BITS = $clog2(FETCH_BLOCK_INSTS);

    fetch_state_t                   state_r;
    logic [31:0]                    pc_r;

    logic [31:0]                    blk_ofs_s;
    logic [SCALAR_BITS-1:0]         count_s;
    logic                           req_valid_s;
    logic                           deliver_s;
    logic [SCALAR_BITS-1:0]         out_count_s;
    logic [31:0]                    word_idx_s;
    logic [31:0]                    lane_pc_s;
    FETCH_PACKET [FETCH_WIDTH-1:0]  packets_s;
    logic                           unused_s;

    assign unused_s  = ^restore_pc[1:0];
    assign blk_ofs_s = block_word_ofs(pc_r, BLK_OFS_BITS);

    fetch_count_calc #(
        .FETCH_BLOCK_INSTS (FETCH_BLOCK_INSTS)
    ) u_count (
        .spots   (bus.inst_buffer_spots),
        .blk_ofs (blk_ofs_s),
        .count   (count_s)
    );

    // Request qualification: a miss keeps re-presenting its address regardless of buffer space.
    always_comb begin
        req_valid_s = 1'b0;
        if (reset || restore_valid) begin
            req_valid_s = 1'b0;
        end else if (state_r == MISS_WAIT) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = (bus.inst_buffer_spots != {SCALAR_BITS{1'b0}});
        end
        deliver_s   = req_valid_s && bus.icache_hit;
        if (deliver_s) begin
            out_count_s = count_s;
        end else begin
            out_count_s = {SCALAR_BITS{1'b0}};
        end
    end

    // Packet lanes: lane i takes block word (offset + i); unused lanes are zero.
    always_comb begin
        packets_s  = '0;
        word_idx_s = 32'd0;
        lane_pc_s  = 32'd0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            word_idx_s = blk_ofs_s + 32'(i);
            lane_pc_s  = pc_r + (32'(i) << 2);
            if ((32'(i) < 32'(out_count_s)) && (word_idx_s < 32'(FETCH_BLOCK_INSTS))) begin
                packets_s[i].inst = bus.icache_data[word_idx_s*32 +: 32];
                packets_s[i].PC   = lane_pc_s;
                packets_s[i].NPC  = lane_pc_s + 32'd4;
            end else begin
                packets_s[i] = '0;
            end
        end
    end

    assign bus.icache_req_valid   = req_valid_s;
    assign bus.icache_req_addr    = block_base(pc_r, BLK_OFS_BITS);
    assign bus.instructions_valid = out_count_s;
    assign bus.inst_buffer_inputs = packets_s;

    // PC and fetch state: reset beats restore, restore discards any coincident hit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= FETCH;
            pc_r    <= 32'd0;
        end else if (restore_valid) begin
            state_r <= FETCH;
            pc_r    <= {restore_pc[31:2], 2'b00};
        end else if (req_valid_s) begin
            if (bus.icache_hit) begin
                state_r <= FETCH;
                pc_r    <= pc_r + (32'(count_s) << 2);
            end else begin
                state_r <= MISS_WAIT;
                pc_r    <= pc_r;
            end
        end else begin
            state_r <= state_r;
            pc_r    <= pc_r;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stat_insts_r;
    logic [31:0] stat_miss_r;
    logic [31:0] stat_full_r;

    // Wrapping activity counters; restore cycles count toward none of them.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_insts_r <= 32'd0;
            stat_miss_r  <= 32'd0;
            stat_full_r  <= 32'd0;
        end else if (restore_valid) begin
            stat_insts_r <= stat_insts_r;
            stat_miss_r  <= stat_miss_r;
            stat_full_r  <= stat_full_r;
        end else begin
            stat_insts_r <= stat_insts_r + 32'(out_count_s);
            if (state_r == MISS_WAIT) begin
                stat_miss_r <= stat_miss_r + 32'd1;
            end else begin
                stat_miss_r <= stat_miss_r;
            end
            if ((state_r == FETCH) && (bus.inst_buffer_spots == {SCALAR_BITS{1'b0}})) begin
                stat_full_r <= stat_full_r + 32'd1;
            end else begin
                stat_full_r <= stat_full_r;
            end
        end
    end

    assign stat_insts_fetched = stat_insts_r;
    assign stat_miss_cycles   = stat_miss_r;
    assign stat_full_cycles   = stat_full_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit (N=3, 4-word blocks) with an expected-result queue.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int FBI = 4;
    localparam int W   = FETCH_WIDTH;
    localparam int SB  = SCALAR_BITS;

    typedef struct {
        logic          rst;
        logic          rv;
        logic [31:0]   rpc;
        logic [SB-1:0] spots;
        logic          hit;
        logic          e_rv;
        logic [31:0]   e_addr;
        logic [SB-1:0] e_cnt;
        logic [31:0]   e_pc0;
    } vec_t;

    typedef struct {
        logic                 rv;
        logic [31:0]          addr;
        logic [SB-1:0]        cnt;
        FETCH_PACKET [W-1:0]  pkts;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        restore_valid;
    logic [31:0] restore_pc;
    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    vec_t        vecs[$];

    always #5 clock = ~clock;

    fetch_unit_if #(.FETCH_BLOCK_INSTS(FBI)) bus ();

`ifdef FETCH_STATS_EN
    logic [31:0] s_insts;
    logic [31:0] s_miss;
    logic [31:0] s_full;
`endif

    fetch_unit #(.FETCH_BLOCK_INSTS(FBI)) dut (
        .clock              (clock),
        .reset              (reset),
        .restore_valid      (restore_valid),
        .restore_pc         (restore_pc),
        .bus                (bus)
`ifdef FETCH_STATS_EN
        ,
        .stat_insts_fetched (s_insts),
        .stat_miss_cycles   (s_miss),
        .stat_full_cycles   (s_full)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC001D00D;
    endfunction

    // Instruction memory model: returns the block at whatever address is presented.
    always_comb begin
        bus.icache_data = '0;
        for (int k = 0; k < FBI; k++) begin
            bus.icache_data[k*32 +: 32] = mem_word(bus.icache_req_addr + 32'(k * 4));
        end
    end

    function automatic vec_t mk(input logic rst, input logic rv, input logic [31:0] rpc,
                                input logic [SB-1:0] spots, input logic hit, input logic e_rv,
                                input logic [31:0] e_addr, input logic [SB-1:0] e_cnt,
                                input logic [31:0] e_pc0);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.spots = spots; v.hit = hit;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_cnt = e_cnt; v.e_pc0 = e_pc0;
        return v;
    endfunction

    function automatic exp_t build(input vec_t v);
        exp_t e;
        logic [31:0] p;
        e.rv   = v.e_rv;
        e.addr = v.e_addr;
        e.cnt  = v.e_cnt;
        e.pkts = '0;
        for (int i = 0; i < W; i++) begin
            if (i < int'(v.e_cnt)) begin
                p = v.e_pc0 + 32'(i * 4);
                e.pkts[i].inst = mem_word(p);
                e.pkts[i].PC   = p;
                e.pkts[i].NPC  = p + 32'd4;
            end
        end
        return e;
    endfunction

    task automatic check_out(input int tag);
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (bus.icache_req_valid !== e.rv) begin
            errors++;
            $display("FAIL req_valid[%0d]: got %b want %b", tag, bus.icache_req_valid, e.rv);
        end
        if (e.rv) begin
            checks++;
            if (bus.icache_req_addr !== e.addr) begin
                errors++;
                $display("FAIL req_addr[%0d]: got %h want %h", tag, bus.icache_req_addr, e.addr);
            end
        end
        checks++;
        if (bus.instructions_valid !== e.cnt) begin
            errors++;
            $display("FAIL inst_valid[%0d]: got %0d want %0d", tag, bus.instructions_valid, e.cnt);
        end
        checks++;
        if (bus.inst_buffer_inputs !== e.pkts) begin
            errors++;
            $display("FAIL packets[%0d]: got %h want %h", tag, bus.inst_buffer_inputs, e.pkts);
        end
    endtask

    task automatic apply(input vec_t v, input int tag);
        @(negedge clock);
        reset                 = v.rst;
        restore_valid         = v.rv;
        restore_pc            = v.rpc;
        bus.inst_buffer_spots = v.spots;
        bus.icache_hit        = v.hit;
        sb.push_back(build(v));
        #1;
        check_out(tag);
    endtask

    initial begin
        reset                 = 1'b1;
        restore_valid         = 1'b0;
        restore_pc            = 32'd0;
        bus.inst_buffer_spots = 2'd0;
        bus.icache_hit        = 1'b0;

        //                rst   rv    rpc            spots hit   e_rv  e_addr         cnt   pc0
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,         2'd3, 1'b1, 1'b0, 32'h0,         2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b1, 1'b1, 32'h0,         2'd3, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b1, 1'b1, 32'h0,         2'd1, 32'hC));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b1, 1'b1, 32'h10,        2'd3, 32'h10));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,         2'd1, 1'b1, 1'b0, 32'h0,         2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd1, 1'b1, 1'b1, 32'h0,         2'd1, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd1, 1'b1, 1'b1, 32'h0,         2'd1, 32'h4));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd1, 1'b1, 1'b1, 32'h0,         2'd1, 32'h8));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd1, 1'b1, 1'b1, 32'h0,         2'd1, 32'hC));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd0, 1'b1, 1'b0, 32'h0,         2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd2, 1'b1, 1'b1, 32'h10,        2'd2, 32'h10));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b1, 1'b1, 32'h10,        2'd2, 32'h18));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b0, 1'b1, 32'h20,        2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b1, 32'h20,        2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b0, 1'b1, 32'h20,        2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b0, 1'b1, 32'h20,        2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b1, 1'b1, 32'h20,        2'd3, 32'h20));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b1, 1'b1, 32'h20,        2'd1, 32'h2C));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b0, 1'b1, 32'h30,        2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h104,       2'd3, 1'b1, 1'b0, 32'h0,         2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b1, 1'b1, 32'h100,       2'd3, 32'h104));
        vecs.push_back(mk(1'b0, 1'b1, 32'h203,       2'd3, 1'b1, 1'b0, 32'h0,         2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b1, 1'b1, 32'h200,       2'd3, 32'h200));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b0, 1'b1, 32'h200,       2'd0, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,         2'd3, 1'b1, 1'b0, 32'h0,         2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd0, 1'b1, 1'b0, 32'h0,         2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b1, 1'b1, 32'h0,         2'd3, 32'h0));
        vecs.push_back(mk(1'b1, 1'b1, 32'h500,       2'd3, 1'b1, 1'b0, 32'h0,         2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd2, 1'b1, 1'b1, 32'h0,         2'd2, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 32'hFFFFFFF8,  2'd3, 1'b0, 1'b0, 32'h0,         2'd0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b1, 1'b1, 32'hFFFFFFF0,  2'd2, 32'hFFFFFFF8));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,         2'd3, 1'b1, 1'b1, 32'h0,         2'd3, 32'h0));

        for (int n = 0; n < vecs.size(); n++) begin
            apply(vecs[n], n);
        end

        // Long miss, then a hit with no buffer space: nothing delivered, back to FETCH.
        apply(mk(1'b0, 1'b0, 32'h0, 2'd3, 1'b0, 1'b1, 32'h0,  2'd0, 32'h0),  100);
        for (int h = 0; h < 3; h++) begin
            apply(mk(1'b0, 1'b0, 32'h0, 2'd1, 1'b0, 1'b1, 32'h0, 2'd0, 32'h0), 101 + h);
        end
        apply(mk(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 32'h0,  2'd0, 32'h0),  104);
        apply(mk(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0,  2'd0, 32'h0),  105);
        apply(mk(1'b0, 1'b0, 32'h0, 2'd1, 1'b1, 1'b1, 32'h0,  2'd1, 32'hC),  106);
        apply(mk(1'b0, 1'b0, 32'h0, 2'd3, 1'b1, 1'b1, 32'h10, 2'd3, 32'h10), 107);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
